// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin mux arbiter slice.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // Largest requester count the picker helper is sized for.
   localparam int MUX_MAX_N = 8;
   localparam int MUX_IDX_W = $clog2(MUX_MAX_N);

   // Round-robin pick: first set bit of req at or above ptr, wrapping modulo n.
   // Returns ptr when nothing is requesting; callers qualify with |req.
   function automatic logic [MUX_IDX_W-1:0] rr_pick(
      input logic [MUX_MAX_N-1:0] req,
      input logic [MUX_IDX_W-1:0] ptr,
      input int                   n
   );
      logic found;
      int   idx;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < MUX_MAX_N; k++) begin
         idx = (int'(ptr) + k) % n;
         if ((k < n) && !found && req[idx[MUX_IDX_W-1:0]]) begin
            rr_pick = MUX_IDX_W'(idx);
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin priority picker over N request lines.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick_comb
   import mux_pkg::*;
#(
   parameter  int N     = 4,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] winner,
   output logic             any
);

   logic [MUX_MAX_N-1:0] req_ext;
   logic [MUX_IDX_W-1:0] ptr_ext;

   // Widen to the helper's fixed size, pick, then narrow back to SEL_W.
   always_comb begin
      req_ext = MUX_MAX_N'(req);
      ptr_ext = MUX_IDX_W'(ptr);
      winner  = SEL_W'(rr_pick(req_ext, ptr_ext, N));
      any     = |req;
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 mux channel; grant is locked until the winner's last beat.
// Latency: one arbitration cycle in IDLE, then beats pass combinationally from the granted requester.
// Backpressure: out_ready routes straight to the granted in_ready; no internal buffering.
// Optional build macro RR_MUX_ARBITER_GRANT_CNT_EN adds saturating per-requester grant counters.
module rr_mux_arbiter
   import mux_pkg::*;
#(
   parameter  int N      = 4,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        in_valid,
   input  logic [N*DATA_W-1:0] in_data,
   input  logic [N-1:0]        in_last,
   output logic [N-1:0]        in_ready,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last,
   input  logic                out_ready,
   output logic [SEL_W-1:0]    sel,
   output logic                busy
`ifdef RR_MUX_ARBITER_GRANT_CNT_EN
   ,
   output logic [N*16-1:0]     grant_cnt
`endif
);

   arb_state_t       state;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] winner;
   logic             any_req;
   logic [SEL_W-1:0] next_ptr;
   logic             fire_last;

   rr_pick_comb #(.N(N)) u_pick (
      .req    (in_valid),
      .ptr    (rr_ptr),
      .winner (winner),
      .any    (any_req)
   );

   // Pointer moves one past the requester whose packet just finished.
   assign next_ptr  = (sel == SEL_W'(N - 1)) ? '0 : sel + SEL_W'(1);
   assign fire_last = (state == LOCK) && out_valid && out_ready && out_last;

   // Mux the granted requester onto the output; everything is quiet outside LOCK.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      in_ready  = '0;
      if (state == LOCK) begin
         out_valid     = in_valid[sel];
         out_data      = in_data[sel*DATA_W +: DATA_W];
         out_last      = in_last[sel];
         in_ready[sel] = out_ready;
      end
   end

   // Arbitrate in IDLE, hold the grant in LOCK until a last beat is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sel    <= '0;
         rr_ptr <= '0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  sel   <= winner;
                  busy  <= 1'b1;
                  state <= LOCK;
               end
            end
            LOCK: begin
               if (fire_last) begin
                  rr_ptr <= next_ptr;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RR_MUX_ARBITER_GRANT_CNT_EN
   // Count each fresh grant per requester, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
      end else if ((state == IDLE) && any_req &&
                   (grant_cnt[winner*16 +: 16] != 16'hFFFF)) begin
         grant_cnt[winner*16 +: 16] <= grant_cnt[winner*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one N:1 multiplexer output channel between N requesters using valid/ready packet handshakes.
- Picks a winner, drives the mux select, and locks the grant until the winner's last beat is accepted.
- Sits in front of the team's mux datapath. Its `sel` output is the select input of the N:1 mux.

Parameters:
- N, 4, number of requesters (2..8).
- DATA_W, 8, width of each requester's data word.
- SEL_W, $clog2(N), select width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N  per-requester beat valid.
- in_data  in  N*DATA_W  packed requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  N  per-requester end-of-packet flag, qualified by in_valid.
- in_ready  out  N  per-requester ready; one-hot or zero.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  muxed data.
- out_last  out  1  muxed last.
- out_ready  in  1  downstream ready.
- sel  out  SEL_W  registered mux select (index of current grant).
- busy  out  1  high while a packet is locked.

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is asynchronous and active-high.
- Reset values: state=IDLE, sel=0, rr_ptr=0, busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0.
- State machine has two states, IDLE and LOCK.
- IDLE:
  - If any in_valid is high, choose a winner by round-robin: search from index rr_ptr upward, wrapping modulo N.
  - Register sel=winner, set busy=1, go to LOCK.
  - Arbitration costs one cycle. The first beat can transfer no earlier than the cycle after the request was seen.
  - With no valid requester, stay in IDLE. sel holds its last value.
- LOCK:
  - out_valid = in_valid[sel]; out_data = in_data[sel]; out_last = in_last[sel]. These are combinational from the registered sel.
  - in_ready[sel] = out_ready. All other in_ready bits are 0.
  - A beat transfers when out_valid && out_ready.
  - A transfer with out_last=1 ends the packet at that edge:
    - rr_ptr <= (sel+1) mod N.
    - busy <= 0.
    - state <= IDLE.
  - Consequence: one idle cycle always separates consecutive packets.
- Outside LOCK: out_valid=0, out_data=0, out_last=0, in_ready all 0.
- Boundary conditions:
  - Winner drops in_valid mid-packet: grant is held, out_valid=0 (bubble), no rearbitration. Other requesters wait.
  - Single-beat packet (in_last on first beat): LOCK lasts exactly the transfer cycle.
  - Winner is index N-1: rr_ptr wraps to 0.
  - All N request continuously: grants rotate 0,1,...,N-1,0. No requester waits more than N-1 packets.
  - out_ready low for any duration: state frozen, data held stable at the source (standard valid/ready rule; no internal buffering).
  - rst asserted mid-packet: immediate return to the reset values above. The partially sent packet is abandoned; downstream must tolerate this.
  - in_last while in_valid=0 is ignored.

Optional Feature:
- Macro: RR_MUX_ARBITER_GRANT_CNT_EN.
- When defined:
  - Adds output port `grant_cnt`, N*16 bits, packed per requester.
  - Entry i increments by 1 at each IDLE->LOCK transition that grants requester i.
  - Counters saturate at 16'hFFFF, not wrap.
  - Reset to 0 by rst.
- When undefined: the port and counters do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package `mux_pkg` holds:
  - `arb_state_t` enum {IDLE, LOCK}.
  - Constant MUX_MAX_N = 8.
  - Function `rr_pick(req, ptr)`, returning the winner index.
- One sub-module: `rr_pick_comb`, a combinational round-robin priority picker (req[N], ptr[SEL_W] -> winner[SEL_W], any).
- The FSM, the mux, and the optional counters stay in `rr_mux_arbiter`.

Test Plan (N=4, DATA_W=8 unless stated):
- Reset release, then in_valid=4'b0100, data2=8'hA5, last2=1, out_ready=1:
  - Cycle 1 after request: sel=2, busy=1.
  - Cycle 2: out_valid=1, out_data=A5, out_last=1, in_ready=4'b0100.
  - Next cycle: busy=0.
- All four valid with continuous 1-beat packets, out_ready=1: grant order 0,1,2,3,0. Packets transfer on every other cycle.
- Requester 1 sends a 3-beat packet with out_ready toggled 1,0,1,0,1 while requester 3 is also valid:
  - sel stays 1 until its third beat transfers.
  - in_ready[3] stays 0 throughout.
  - Requester 3 is granted next.
- Requester 0 drops in_valid for 2 cycles mid-packet: out_valid=0 for those cycles, sel stays 0, no grant to pending requester 2.
- Assert rst in the second beat of a packet: all outputs return to reset values asynchronously; after release, rr_ptr=0 (a request on 0 and 3 grants 0).
- With RR_MUX_ARBITER_GRANT_CNT_EN: 5 grants to requester 2 give grant_cnt[2]=5. Forcing 65536 grants leaves it at 16'hFFFF.
